// File: rtl/muldiv_if.sv
// Execute-stage bundle between the control/datapath side and the multiply/divide unit.
// StartE is a request taken only while the unit is idle (no ready, no queuing); DoneE marks ResultLoE/ResultHiE valid for one cycle.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic             FlushE;
  logic [1:0]       OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [WIDTH-1:0] ResultLoE;
  logic [WIDTH-1:0] ResultHiE;
  logic             BusyE;
  logic             DoneE;
  logic             StallMulE;

  modport master (
    output StartE, FlushE, OpE, SrcAE, SrcBE,
    input  ResultLoE, ResultHiE, BusyE, DoneE, StallMulE
  );

  modport slave (
    input  StartE, FlushE, OpE, SrcAE, SrcBE,
    output ResultLoE, ResultHiE, BusyE, DoneE, StallMulE
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Operands are reduced to magnitudes at launch; signs are re-applied on the last iteration.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic       clk,
  input  logic       reset,
  muldiv_if.slave    bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic             neg_q, neg_d, rneg_q, rneg_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = bus.OpE[0] & bus.SrcAE[WIDTH-1];
  assign b_neg = bus.OpE[0] & bus.SrcBE[WIDTH-1];
  assign a_mag = a_neg ? -bus.SrcAE : bus.SrcAE;
  assign b_mag = b_neg ? -bus.SrcBE : bus.SrcBE;

  // hi_q is the running product high half / partial remainder; lo_q holds the
  // multiplier bits (shifted out LSB first) or dividend bits (shifted out MSB first).
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (op_q[1]) begin
      if (div_trial[WIDTH]) begin
        step_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_raw = {step_hi, step_lo};
  assign prod_fix = neg_q ? -prod_raw : prod_raw;
  assign quo_fix  = neg_q ? -step_lo : step_lo;
  assign rem_fix  = rneg_q ? -step_hi : step_hi;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    case (state_q)
      S_IDLE: begin
        if (bus.StartE && !bus.FlushE) begin
          op_d = bus.OpE;
          if (bus.OpE[1] && (bus.SrcBE == '0)) begin
            res_lo_d = '0;
            res_hi_d = bus.SrcAE;
            state_d  = S_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = bus.OpE[1] ? a_mag : b_mag;
            b_d     = bus.OpE[1] ? b_mag : a_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = CNTW'(WIDTH - 1);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.FlushE) begin
          state_d = S_IDLE;
        end else begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            if (op_q[1]) begin
              res_lo_d = quo_fix;
              res_hi_d = rem_fix;
            end else begin
              res_lo_d = prod_fix[WIDTH-1:0];
              res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  // A flush arriving in the DONE cycle swallows the pulse.
  assign bus.DoneE     = (state_q == S_DONE) & ~bus.FlushE;
  assign bus.BusyE     = (state_q == S_RUN);
  assign bus.StallMulE = ((state_q == S_IDLE) & bus.StartE & ~bus.FlushE & ~reset) |
                         (state_q == S_RUN);
  assign bus.ResultLoE = res_lo_q;
  assign bus.ResultHiE = res_hi_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected results and cycle-level
// expectations; a negedge monitor compares DUT outputs and pops results on DoneE.
module tb_muldiv_unit;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .CNTW(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard state and bench-owned expectations
  logic [2*W-1:0] exp_q[$];
  logic           exp_stall = 1'b0;
  logic           exp_busy  = 1'b0;
  logic           exp_done  = 1'b0;
  logic           chk_res   = 1'b1;
  logic [W-1:0]   exp_res_hi = '0;
  logic [W-1:0]   exp_res_lo = '0;
  logic           final_req = 1'b0;
  int             errors = 0;
  int             checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    chk("stall", 64'(bus.StallMulE), 64'(exp_stall));
    chk("busy",  64'(bus.BusyE),     64'(exp_busy));
    chk("done",  64'(bus.DoneE),     64'(exp_done));
    if (chk_res) begin
      chk("held_hi", 64'(bus.ResultHiE), 64'(exp_res_hi));
      chk("held_lo", 64'(bus.ResultLoE), 64'(exp_res_lo));
    end
    if (bus.DoneE) begin
      chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result_hi", 64'(bus.ResultHiE), 64'(e[2*W-1:W]));
        chk("result_lo", 64'(bus.ResultLoE), 64'(e[W-1:0]));
      end
    end
    if (final_req) chk("sb_drained", 64'(exp_q.size()), 64'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation at t0 and walk it through its expected timeline.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                        input bit start_in_done);
    bus.OpE    = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    bus.StartE = 1'b1;
    exp_stall  = 1'b1;
    exp_busy   = 1'b0;
    exp_done   = 1'b0;
    exp_q.push_back({e_hi, e_lo});
    step();
    bus.StartE = 1'b0;
    bus.SrcAE  = $urandom;
    bus.SrcBE  = $urandom;
    if (op[1] && (b == '0)) begin
      exp_stall = 1'b0;
      exp_done  = 1'b1;
    end else begin
      exp_busy = 1'b1;
      for (int i = 1; i < W; i++) step();
      step();
      exp_stall = 1'b0;
      exp_busy  = 1'b0;
      exp_done  = 1'b1;
    end
    if (start_in_done) bus.StartE = 1'b1;
    step();
    exp_done   = 1'b0;
    bus.StartE = 1'b0;
    if (start_in_done) step();
  endtask

  initial begin
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    bus.OpE    = 2'b00;
    bus.SrcAE  = '0;
    bus.SrcBE  = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    chk_res = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, 1'b1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op(2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'd0,         1'b0);
    run_op(2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'd0,         1'b1);

    // Flush mid-RUN: ignored restart at t5, flush at t10, no done afterwards.
    bus.OpE    = 2'b00;
    bus.SrcAE  = 32'd1234;
    bus.SrcBE  = 32'd5678;
    bus.StartE = 1'b1;
    exp_stall  = 1'b1;
    step();
    bus.StartE = 1'b0;
    exp_busy   = 1'b1;
    repeat (4) step();
    bus.StartE = 1'b1;
    bus.OpE    = 2'b10;
    step();
    bus.StartE = 1'b0;
    repeat (4) step();
    bus.FlushE = 1'b1;
    step();
    bus.FlushE = 1'b0;
    exp_stall  = 1'b0;
    exp_busy   = 1'b0;
    exp_res_hi = 32'h0000_1234;
    exp_res_lo = 32'd0;
    chk_res    = 1'b1;
    repeat (30) step();
    chk_res = 1'b0;

    // Asynchronous reset between edges during RUN.
    bus.OpE    = 2'b01;
    bus.SrcAE  = 32'hFFFF_0000;
    bus.SrcBE  = 32'h0000_0077;
    bus.StartE = 1'b1;
    exp_stall  = 1'b1;
    step();
    bus.StartE = 1'b0;
    exp_busy   = 1'b1;
    repeat (14) step();
    #1;
    reset      = 1'b1;
    exp_stall  = 1'b0;
    exp_busy   = 1'b0;
    exp_res_hi = '0;
    exp_res_lo = '0;
    chk_res    = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (40) step();
    chk_res = 1'b0;

    run_op(2'b10, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

    final_req = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
